// File: rtl/chan_pipe_array_if.sv
// Handshake bundle for chan_pipe_array: per-channel push side, pop side, flush and status.
// Master drives pushes, pops and flushes; slave (the buffer array) drives ready, valid, data and status.
interface chan_pipe_array_if #(
    parameter int W     = 1,
    parameter int NCH   = 4,
    parameter int DEPTH = 2
);
    localparam int L = $clog2(DEPTH + 1);

    logic [NCH-1:0]   i_valid;
    logic [NCH*W-1:0] i_data;
    logic [NCH-1:0]   i_ready;
    logic [NCH-1:0]   o_valid;
    logic [NCH*W-1:0] o_data;
    logic [NCH-1:0]   o_ready;
    logic [NCH-1:0]   flush;
    logic [NCH*L-1:0] o_level;
    logic [NCH-1:0]   ovf;

    modport master (
        output i_valid, i_data, o_ready, flush,
        input  i_ready, o_valid, o_data, o_level, ovf
    );

    modport slave (
        input  i_valid, i_data, o_ready, flush,
        output i_ready, o_valid, o_data, o_level, ovf
    );
endinterface

// File: rtl/chan_pipe_array.sv
// NCH independent DEPTH-entry FIFOs; 1-cycle push-to-head latency from registered storage.
// i_ready drops when full with no pass-through; pushes against a full channel set a sticky ovf.
module chan_pipe_array #(
    parameter int W     = 1,
    parameter int NCH   = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    chan_pipe_array_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int L  = $clog2(DEPTH + 1);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0]     mem_q  [NCH][DEPTH];
    logic [AW:0]      wptr_q [NCH];
    logic [AW:0]      wptr_d [NCH];
    logic [AW:0]      rptr_q [NCH];
    logic [AW:0]      rptr_d [NCH];
    logic [NCH-1:0]   ovf_q;
    logic [NCH-1:0]   ovf_d;

    logic [NCH-1:0]   full;
    logic [NCH-1:0]   empty;
    logic [NCH-1:0]   rdy;
    logic [NCH-1:0]   push;
    logic [NCH-1:0]   pop;
    logic [NCH*W-1:0] head_dat;
    logic [NCH*L-1:0] level;

    // Pointers carry an extra wrap bit so full and empty are distinguishable at equal index.
    always_comb begin
        full     = '0;
        empty    = '0;
        rdy      = '0;
        push     = '0;
        pop      = '0;
        head_dat = '0;
        level    = '0;
        for (int c = 0; c < NCH; c++) begin
            full[c]  = (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]) &&
                       (wptr_q[c][AW] != rptr_q[c][AW]);
            empty[c] = (wptr_q[c] == rptr_q[c]);
            rdy[c]   = !full[c] && !rst;
            push[c]  = bus.i_valid[c] && rdy[c];
            pop[c]   = !empty[c] && bus.o_ready[c];
            head_dat[c*W +: W] = mem_q[c][rptr_q[c][AW-1:0]];
            level[c*L +: L]    = L'(wptr_q[c] - rptr_q[c]);
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        for (int c = 0; c < NCH; c++) begin
            if (bus.flush[c]) begin
                wptr_d[c] = '0;
                rptr_d[c] = '0;
                ovf_d[c]  = 1'b0;
            end else begin
                if (push[c]) begin
                    wptr_d[c] = wptr_q[c] + PTR_ONE;
                end
                if (pop[c]) begin
                    rptr_d[c] = rptr_q[c] + PTR_ONE;
                end
                if (bus.i_valid[c] && !rdy[c]) begin
                    ovf_d[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
            end
            ovf_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage is never reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c]) begin
                mem_q[c][wptr_q[c][AW-1:0]] <= bus.i_data[c*W +: W];
            end
        end
    end

    assign bus.i_ready = rdy;
    assign bus.o_valid = ~empty;
    assign bus.o_data  = head_dat;
    assign bus.o_level = level;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_chan_pipe_array.sv
// Bench for chan_pipe_array: directed scenarios on a DEPTH=2 instance, random traffic on DEPTH=8.
// A queue-per-channel reference model is checked every cycle by a negedge monitor.
module tb_chan_pipe_array;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    chan_pipe_array_if #(.W(8), .NCH(4), .DEPTH(2)) bus_a ();
    chan_pipe_array_if #(.W(8), .NCH(4), .DEPTH(8)) bus_b ();

    chan_pipe_array #(.W(8), .NCH(4), .DEPTH(2)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    chan_pipe_array #(.W(8), .NCH(4), .DEPTH(8)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    // Reference model: channel k of instance d lives at index d*4+k.
    logic [7:0] mq [8][$];
    bit         movf  [8];
    int         npop  [8];
    bit         armed [2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int d, input int depth, input int lw, input bit rst,
                       input logic [3:0] iv, input logic [31:0] idat, input logic [3:0] ir,
                       input logic [3:0] ov, input logic [31:0] od, input logic [3:0] ordy,
                       input logic [3:0] fl, input logic [15:0] lvl, input logic [3:0] ovf);
        for (int c = 0; c < 4; c++) begin
            int k;
            int sz;
            int lv;
            bit acc;
            logic [7:0] exp_dat;
            k  = d * 4 + c;
            sz = mq[k].size();
            lv = int'((lvl >> (c * lw)) & 16'((1 << lw) - 1));
            if (armed[d]) begin
                chk($sformatf("u%0d ch%0d i_ready", d, c), int'(ir[c]), int'(!rst && sz < depth));
                chk($sformatf("u%0d ch%0d o_valid", d, c), int'(ov[c]), int'(sz != 0));
                chk($sformatf("u%0d ch%0d o_level", d, c), lv, sz);
                chk($sformatf("u%0d ch%0d ovf", d, c), int'(ovf[c]), int'(movf[k]));
            end
            if (rst || fl[c]) begin
                mq[k].delete();
                movf[k] = 1'b0;
            end else begin
                acc = iv[c] && (sz < depth);
                if (iv[c] && !acc) movf[k] = 1'b1;
                if (ordy[c] && sz != 0) begin
                    exp_dat = mq[k].pop_front();
                    npop[k]++;
                    if (armed[d])
                        chk($sformatf("u%0d ch%0d pop data", d, c), int'(od[c*8 +: 8]), int'(exp_dat));
                end
                if (acc) mq[k].push_back(idat[c*8 +: 8]);
            end
        end
        if (rst) armed[d] = 1'b1;
    endtask

    always @(negedge clk) begin
        mon(0, 2, 2, rst_a, bus_a.i_valid, bus_a.i_data, bus_a.i_ready, bus_a.o_valid,
            bus_a.o_data, bus_a.o_ready, bus_a.flush, {8'h00, bus_a.o_level}, bus_a.ovf);
        mon(1, 8, 4, rst_b, bus_b.i_valid, bus_b.i_data, bus_b.i_ready, bus_b.o_valid,
            bus_b.o_data, bus_b.o_ready, bus_b.flush, bus_b.o_level, bus_b.ovf);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lvl_a(input int c);
        return int'(bus_a.o_level[c*2 +: 2]);
    endfunction

    function automatic int od_a(input int c);
        return int'(bus_a.o_data[c*8 +: 8]);
    endfunction

    task automatic directed_a();
        tick();
        chk("rst release i_ready", int'(bus_a.i_ready), 4'hF);
        // Fill ch0 and overflow it
        bus_a.i_valid = 4'b0001; bus_a.i_data[7:0] = 8'h11;
        tick();
        bus_a.i_data[7:0] = 8'h22;
        tick();
        chk("ch0 full i_ready", int'(bus_a.i_ready[0]), 0);
        chk("ch0 full level", lvl_a(0), 2);
        chk("ch0 ovf before", int'(bus_a.ovf[0]), 0);
        bus_a.i_data[7:0] = 8'h33;
        tick();
        chk("ch0 ovf set", int'(bus_a.ovf[0]), 1);
        chk("ch0 level hold", lvl_a(0), 2);
        // Pop while pushing into a full channel: no pass-through
        bus_a.o_ready = 4'b0001;
        tick();
        chk("ch0 no passthru level", lvl_a(0), 1);
        chk("ch0 head after pop", od_a(0), 8'h22);
        bus_a.i_valid = 4'b0000; bus_a.o_ready = 4'b0000;
        // Steady push+pop on ch1 across pointer wrap
        bus_a.i_valid = 4'b0010; bus_a.i_data[15:8] = 8'hA0;
        tick();
        chk("ch1 level primed", lvl_a(1), 1);
        for (int k = 0; k < 10; k++) begin
            bus_a.o_ready = 4'b0010;
            bus_a.i_data[15:8] = 8'(8'hA1 + k);
            tick();
            chk($sformatf("ch1 steady level %0d", k), lvl_a(1), 1);
            chk($sformatf("ch1 steady head %0d", k), od_a(1), 8'hA1 + k);
        end
        bus_a.i_valid = 4'b0000; bus_a.o_ready = 4'b0000;
        // Overflow ch2, then flush it alongside a push
        bus_a.i_valid = 4'b1100; bus_a.i_data[23:16] = 8'h50; bus_a.i_data[31:24] = 8'h66;
        tick();
        bus_a.i_valid = 4'b0100; bus_a.i_data[23:16] = 8'h51;
        tick();
        bus_a.i_data[23:16] = 8'h52;
        tick();
        chk("ch2 ovf before flush", int'(bus_a.ovf[2]), 1);
        chk("ch2 level before flush", lvl_a(2), 2);
        bus_a.flush = 4'b0100; bus_a.i_data[23:16] = 8'h77;
        tick();
        chk("ch2 flush level", lvl_a(2), 0);
        chk("ch2 flush o_valid", int'(bus_a.o_valid[2]), 0);
        chk("ch2 flush ovf", int'(bus_a.ovf[2]), 0);
        chk("ch0 untouched", lvl_a(0), 1);
        chk("ch1 untouched", lvl_a(1), 1);
        chk("ch3 untouched", lvl_a(3), 1);
        chk("ch0 ovf untouched", int'(bus_a.ovf[0]), 1);
        bus_a.flush = 4'b0000; bus_a.i_valid = 4'b0000;
        // Fill everything, then a one-cycle reset
        bus_a.i_valid = 4'b1111; bus_a.i_data = 32'hC3C2C1C0;
        tick();
        tick();
        chk("all full i_ready", int'(bus_a.i_ready), 0);
        chk("all full level", int'(bus_a.o_level), 8'hAA);
        bus_a.i_valid = 4'b0000; rst_a = 1'b1;
        tick();
        chk("rst o_valid", int'(bus_a.o_valid), 0);
        chk("rst o_level", int'(bus_a.o_level), 0);
        chk("rst ovf", int'(bus_a.ovf), 0);
        chk("rst i_ready", int'(bus_a.i_ready), 0);
        rst_a = 1'b0;
        tick();
        chk("post rst i_ready", int'(bus_a.i_ready), 4'hF);
        chk("post rst o_valid", int'(bus_a.o_valid), 0);
    endtask

    task automatic random_b();
        logic [3:0] iv;
        logic [3:0] ordy;
        logic [3:0] fl;
        for (int n = 0; n < 2000; n++) begin
            for (int c = 0; c < 4; c++) begin
                iv[c]   = ($urandom_range(0, 9) < 6);
                ordy[c] = ($urandom_range(0, 9) < 5);
                fl[c]   = ($urandom_range(0, 39) == 0);
            end
            bus_b.i_valid = iv;
            bus_b.o_ready = ordy;
            bus_b.flush   = fl;
            bus_b.i_data  = $urandom;
            rst_b = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst_b = 1'b0;
        bus_b.i_valid = 4'b0000;
        bus_b.flush   = 4'b0000;
        bus_b.o_ready = 4'b1111;
        repeat (12) tick();
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.i_valid = '0; bus_a.i_data = '0; bus_a.o_ready = '0; bus_a.flush = '0;
        bus_b.i_valid = '0; bus_b.i_data = '0; bus_b.o_ready = '0; bus_b.flush = '0;
        repeat (2) tick();
        chk("reset o_valid", int'(bus_a.o_valid), 0);
        chk("reset o_level", int'(bus_a.o_level), 0);
        chk("reset ovf", int'(bus_a.ovf), 0);
        chk("reset i_ready", int'(bus_a.i_ready), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        fork
            directed_a();
            random_b();
        join
        tick();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("u1 ch%0d traffic popped", c), int'(npop[4 + c] > 50), 1);
            chk($sformatf("u1 ch%0d drained", c), mq[4 + c].size(), 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
